// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage load/store sequencer onto a valid/ready data bus, with
//            lane steering, load extension, alignment and timeout detection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  ls_op,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err_align,
    output logic        err_timeout,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_byteen,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;
    localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_op;
    logic        r_sign;
    logic [1:0]  r_off;

    logic        w_aligned;
    logic [3:0]  w_byteen;
    logic        w_accept;
    logic        w_misalign;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    always_comb begin
        w_aligned = 1'b1;
        w_byteen  = 4'b0000;
        case (ls_op)
            2'b01: begin
                w_aligned = ~req_addr[0];
                w_byteen  = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_aligned = 1'b1;
                w_byteen  = 4'b0001 << req_addr[1:0];
            end
            default: begin
                w_aligned = (req_addr[1:0] == 2'b00);
                w_byteen  = 4'b1111;
            end
        endcase
        if (!req_we) begin
            w_byteen = 4'b0000;
        end
    end

    assign w_accept   = (r_state == c_IDLE) && req_valid && w_aligned;
    assign w_misalign = (r_state == c_IDLE) && req_valid && !w_aligned;

    // Bring the addressed byte/half down to bit 0 before extending it.
    assign w_shifted = bus_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load = bus_rdata;
        case (r_op)
            2'b01:   w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            2'b10:   w_load = {{24{r_sign & w_shifted[7]}}, w_shifted[7:0]};
            default: w_load = bus_rdata;
        endcase
        if (bus_we) begin
            w_load = 32'd0;
        end
    end

    assign bus_valid   = (r_state == c_BUSY);
    assign rdata_valid = (r_state == c_DONE);
    // Gated by reset so the pipeline is released while reset is held.
    assign stall       = reset && (w_accept || (r_state == c_BUSY));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= 8'd0;
            r_op        <= 2'b00;
            r_sign      <= 1'b0;
            r_off       <= 2'b00;
            rdata       <= 32'd0;
            err_align   <= 1'b0;
            err_timeout <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'd0;
            bus_byteen  <= 4'b0000;
            bus_wdata   <= 32'd0;
        end else begin
            err_align   <= w_misalign;
            err_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        bus_we     <= req_we;
                        bus_addr   <= {req_addr[31:2], 2'b00};
                        bus_byteen <= w_byteen;
                        bus_wdata  <= req_wdata << {req_addr[1:0], 3'b000};
                        r_op       <= ls_op;
                        r_sign     <= req_sign;
                        r_off      <= req_addr[1:0];
                        r_cnt      <= 8'd0;
                        r_state    <= c_BUSY;
                    end
                end
                c_BUSY: begin
                    if (bus_ready) begin
                        rdata   <= w_load;
                        r_cnt   <= 8'd0;
                        r_state <= c_DONE;
                    end else if (r_cnt == c_LAST) begin
                        rdata       <= 32'd0;
                        err_timeout <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= c_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Randomised and directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  ls_op = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err_align;
    logic        err_timeout;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'd0;

    int total = 0;
    int bad   = 0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .ls_op(ls_op), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err_align(err_align),
        .err_timeout(err_timeout), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: access size in bytes, natural alignment, lane masks.
    function automatic int m_size(input logic [1:0] op);
        return (op == 2'b01) ? 2 : (op == 2'b10) ? 1 : 4;
    endfunction

    function automatic logic m_aligned(input logic [1:0] op, input logic [31:0] a);
        return (a % m_size(op)) == 0;
    endfunction

    function automatic logic [3:0] m_byteen(input logic we, input logic [1:0] op, input logic [31:0] a);
        int m;
        if (!we) return 4'b0000;
        m = ((1 << m_size(op)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] m_lanes(input logic [3:0] be);
        logic [31:0] m = 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] op, input logic sg,
                                          input logic [31:0] a, input logic [31:0] rd);
        int bits;
        logic [31:0] v, mask;
        if (m_size(op) == 4) return rd;
        bits = 8 * m_size(op);
        mask = (32'd1 << bits) - 32'd1;
        v = (rd >> (8 * (a % 4))) & mask;
        if (sg && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Drives one request and records what the DUT did; lat = BUSY cycles before ready.
    task automatic run_access(
        input logic we, input logic [1:0] op, input logic sg,
        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd, input int lat,
        output logic st0, output int busy_n, output logic st_busy, output logic held,
        output logic [31:0] baddr, output logic [31:0] bwd, output logic [3:0] bben,
        output logic bwe, output logic done, output logic ea, output logic et,
        output logic [31:0] rdo, output int cyc);
        req_we = we; ls_op = op; req_sign = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1; bus_ready = 1'b0;
        #1;
        st0 = stall;
        busy_n = 0; st_busy = 1'b1; held = 1'b1; done = 1'b0; ea = 1'b0; et = 1'b0;
        baddr = '0; bwd = '0; bben = '0; bwe = 1'b0; rdo = 32'hxxxx_xxxx; cyc = -1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(posedge clk); #1;
            if (bus_valid) begin
                if (busy_n == 0) begin
                    baddr = bus_addr; bwd = bus_wdata; bben = bus_byteen; bwe = bus_we;
                end else if (bus_addr !== baddr || bus_wdata !== bwd ||
                             bus_byteen !== bben || bus_we !== bwe) begin
                    held = 1'b0;
                end
                if (!stall) st_busy = 1'b0;
                bus_ready = (busy_n == lat);
                bus_rdata = (busy_n == lat) ? rd : $urandom;
                busy_n++;
            end else begin
                bus_ready = 1'b0;
            end
            if (rdata_valid || err_align || err_timeout) begin
                done = rdata_valid; ea = err_align; et = err_timeout;
                rdo = rdata; cyc = k;
                break;
            end
        end
        req_valid = 1'b0; bus_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    logic        st0, st_busy, held, bwe, done, ea, et;
    int          busy_n, cyc;
    logic [31:0] baddr, bwd, rdo;
    logic [3:0]  bben;

    task automatic test_reset();
        reset = 1'b0;
        #3;
        total++; if ({stall, bus_valid, rdata_valid, err_align, err_timeout, bus_we} !== 6'd0) begin bad++; $display("FAIL reset_ctrl: got %b want 000000", {stall, bus_valid, rdata_valid, err_align, err_timeout, bus_we}); end
        total++; if ({rdata, bus_addr, bus_wdata, bus_byteen} !== 100'd0) begin bad++; $display("FAIL reset_data: got %h/%h/%h/%b want zeros", rdata, bus_addr, bus_wdata, bus_byteen); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 0,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (st0 !== 1'b1) begin bad++; $display("FAIL sw_stall0: got %b want 1", st0); end
        total++; if (busy_n !== 1) begin bad++; $display("FAIL sw_busy_cycles: got %0d want 1", busy_n); end
        total++; if (bben !== 4'b1111 || bwe !== 1'b1) begin bad++; $display("FAIL sw_byteen: got %b/%b want 1111/1", bben, bwe); end
        total++; if (bwd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL sw_wdata: got %h want deadbeef", bwd); end
        total++; if (done !== 1'b1 || cyc !== 2 || rdo !== 32'd0) begin bad++; $display("FAIL sw_done: got %b@%0d rdata %h want 1@2 0", done, cyc, rdo); end
        run_access(1'b1, 2'b10, 1'b0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 0,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (bben !== 4'b1000) begin bad++; $display("FAIL sb_byteen: got %b want 1000", bben); end
        total++; if (bwd[31:24] !== 8'hA5 || baddr !== 32'h0000_1000) begin bad++; $display("FAIL sb_lane: got %h@%h want a5@00001000", bwd[31:24], baddr); end
    endtask

    task automatic test_loads();
        run_access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 1,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (rdo !== 32'hFFFF_8001 || done !== 1'b1) begin bad++; $display("FAIL lh_signed: got %h want ffff8001", rdo); end
        total++; if (bben !== 4'b0000 || bwe !== 1'b0) begin bad++; $display("FAIL lh_byteen: got %b/%b want 0000/0", bben, bwe); end
        run_access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (rdo !== 32'h0000_8001) begin bad++; $display("FAIL lhu: got %h want 00008001", rdo); end
        run_access(1'b0, 2'b10, 1'b0, 32'h0000_2000, 32'h0, 32'h8001_1234, 2,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (rdo !== 32'h0000_0034) begin bad++; $display("FAIL lbu: got %h want 00000034", rdo); end
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_3002, 32'h0, 32'h0, 0,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (ea !== 1'b1 || cyc !== 1) begin bad++; $display("FAIL align_pulse: got %b@%0d want 1@1", ea, cyc); end
        total++; if (busy_n !== 0 || st0 !== 1'b0) begin bad++; $display("FAIL align_nobus: got busy=%0d stall=%b want 0/0", busy_n, st0); end
        @(posedge clk); #1;
        total++; if (err_align !== 1'b0) begin bad++; $display("FAIL align_one_shot: got %b want 0", err_align); end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, 1000,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (busy_n !== TIMEOUT) begin bad++; $display("FAIL tmo_busy_cycles: got %0d want %0d", busy_n, TIMEOUT); end
        total++; if (et !== 1'b1 || done !== 1'b0 || rdo !== 32'd0) begin bad++; $display("FAIL tmo_pulse: got et=%b done=%b rdata=%h want 1/0/0", et, done, rdo); end
        total++; if (bus_valid !== 1'b0 || err_timeout !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %b/%b want 0/0", bus_valid, err_timeout); end
        run_access(1'b0, 2'b00, 1'b0, 32'h0000_4000, 32'h0, 32'h1234_5678, TIMEOUT - 1,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (done !== 1'b1 || et !== 1'b0 || busy_n !== TIMEOUT || rdo !== 32'h1234_5678) begin bad++; $display("FAIL tmo_last_ready: got done=%b et=%b busy=%0d rdata=%h want 1/0/%0d/12345678", done, et, busy_n, rdo, TIMEOUT); end
    endtask

    task automatic test_reset_mid_busy();
        req_we = 1'b0; ls_op = 2'b00; req_addr = 32'h0000_5000; req_valid = 1'b1; bus_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        total++; if (bus_valid !== 1'b1) begin bad++; $display("FAIL rst_busy_pre: got %b want 1", bus_valid); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus_valid !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_busy_drop: got valid=%b stall=%b want 0/0", bus_valid, stall); end
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_access(1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, 0,
                   st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
        total++; if (done !== 1'b1 || cyc !== 2 || bwd !== 32'hCAFE_F00D) begin bad++; $display("FAIL rst_recover: got done=%b@%0d wdata=%h want 1@2 cafef00d", done, cyc, bwd); end
    endtask

    task automatic test_random();
        logic        we, sg;
        logic [1:0]  op;
        logic [31:0] a, wd, rd, lanes;
        int          lat;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom); sg = 1'($urandom); op = 2'($urandom);
            a = $urandom; wd = $urandom; rd = $urandom; lat = $urandom_range(0, 4);
            run_access(we, op, sg, a, wd, rd, lat,
                       st0, busy_n, st_busy, held, baddr, bwd, bben, bwe, done, ea, et, rdo, cyc);
            if (m_aligned(op, a)) begin
                lanes = m_lanes(m_byteen(we, op, a));
                total++; if (done !== 1'b1 || cyc !== lat + 2 || busy_n !== lat + 1) begin bad++; $display("FAIL rnd_timing[%0d]: got done=%b@%0d busy=%0d want 1@%0d %0d", n, done, cyc, busy_n, lat + 2, lat + 1); end
                total++; if (st0 !== 1'b1 || st_busy !== 1'b1 || held !== 1'b1) begin bad++; $display("FAIL rnd_stall_hold[%0d]: got %b%b%b want 111", n, st0, st_busy, held); end
                total++; if (baddr !== (a & 32'hFFFF_FFFC) || bwe !== we || bben !== m_byteen(we, op, a)) begin bad++; $display("FAIL rnd_bus[%0d]: got %h/%b/%b want %h/%b/%b", n, baddr, bwe, bben, a & 32'hFFFF_FFFC, we, m_byteen(we, op, a)); end
                total++; if ((bwd & lanes) !== ((wd << (8 * (a % 4))) & lanes)) begin bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", n, bwd & lanes, (wd << (8 * (a % 4))) & lanes); end
                total++; if (rdo !== (we ? 32'd0 : m_load(op, sg, a, rd))) begin bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", n, rdo, we ? 32'd0 : m_load(op, sg, a, rd)); end
            end else begin
                total++; if (ea !== 1'b1 || busy_n !== 0 || st0 !== 1'b0) begin bad++; $display("FAIL rnd_align[%0d]: got ea=%b busy=%0d stall=%b want 1/0/0", n, ea, busy_n, st0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misaligned();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
